// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared pattern modes, default VGA timing and total helpers
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_BORDER  = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int MAX_TOTAL    = 1024;

  function automatic int timing_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - h/v raster counters with sync-window and visible-region decode
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       line_end,
  output logic       hsync,
  output logic       vsync,
  output logic       active
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
    $error("vga_timing: line or frame total exceeds 10-bit counter range");
  end

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);

  assign line_end = (h == H_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (en) begin
      if (line_end) begin
        h <= '0;
        v <= (v == V_MAX) ? 10'd0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  // vsync depends on the line count only, so it spans whole lines
  assign hsync  = (h >= HS_FIRST && h <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
  assign vsync  = (v >= VS_FIRST && v <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
  assign active = (h < H_VIS) && (v < V_VIS);

endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - VGA timing plus frame-latched test patterns behind one output register
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int COLOR_W    = 3,
  parameter int NUM_BARS   = 8,
  parameter int CHECK_LOG2 = 5,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] solid_color,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic [9:0]         x,
  output logic [9:0]         y,
  output logic [COLOR_W-1:0] color,
  output logic               frame_start,
  output logic [15:0]        frame_count
);

  if (H_ACTIVE % NUM_BARS != 0) begin : g_bar_check
    $error("vga_pattern_gen: H_ACTIVE must be divisible by NUM_BARS");
  end

  localparam int BAR_W = H_ACTIVE / NUM_BARS;
  localparam logic [9:0] BAR_LAST = 10'(BAR_W - 1);
  localparam logic [9:0] H_EDGE   = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_EDGE   = 10'(V_ACTIVE - 1);

  logic [9:0] h, v;
  logic       line_end, t_hsync, t_vsync, t_active;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL)
  ) u_timing (
    .clk(clk), .rst(rst), .en(en),
    .h(h), .v(v), .line_end(line_end),
    .hsync(t_hsync), .vsync(t_vsync), .active(t_active)
  );

  // bar_cnt/bar_idx track h so the bar index never needs a divider
  logic [9:0]         bar_cnt;
  logic [COLOR_W-1:0] bar_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (en) begin
      if (line_end) begin
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (bar_cnt == BAR_LAST) begin
        bar_cnt <= '0;
        bar_idx <= bar_idx + COLOR_W'(1);
      end else begin
        bar_cnt <= bar_cnt + 10'd1;
      end
    end
  end

  mode_e              mode_q, cur_mode;
  logic [COLOR_W-1:0] solid_q, cur_solid, pix;
  logic               origin, started;

  // the pixel at (0,0) already uses the freshly sampled selection
  always_comb begin
    origin    = (h == 10'd0) && (v == 10'd0);
    cur_mode  = origin ? mode_e'(mode) : mode_q;
    cur_solid = origin ? solid_color : solid_q;
    pix       = '0;
    case (cur_mode)
      MODE_BARS:    pix = bar_idx;
      MODE_CHECKER: pix = {COLOR_W{h[CHECK_LOG2] ^ v[CHECK_LOG2]}};
      MODE_BORDER:  pix = {COLOR_W{(h == 10'd0) || (h == H_EDGE) || (v == 10'd0) || (v == V_EDGE)}};
      MODE_SOLID:   pix = cur_solid;
      default:      pix = '0;
    endcase
    if (!t_active) pix = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_BARS;
      solid_q     <= '0;
      started     <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      active      <= 1'b0;
      x           <= '0;
      y           <= '0;
      color       <= '0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else if (en) begin
      if (origin) begin
        mode_q  <= cur_mode;
        solid_q <= cur_solid;
        started <= 1'b1;
        if (started) frame_count <= frame_count + 16'd1;
      end
      hsync       <= t_hsync;
      vsync       <= t_vsync;
      active      <= t_active;
      x           <= h;
      y           <= v;
      color       <= pix;
      frame_start <= origin;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - randomized bench for vga_pattern_gen against a raster-level model
module tb_vga_pattern_gen;

  localparam int HA = 16, HFP = 2, HS = 3, HB = 3;
  localparam int VA = 12, VFP = 2, VS = 2, VB = 2;
  localparam int CW = 3, NB = 4, CL = 2;
  localparam bit POL = 1'b0;
  localparam int HT = HA + HFP + HS + HB;
  localparam int VT = VA + VFP + VS + VB;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1, en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [CW-1:0] solid = '0;
  logic          hsync, vsync, active, frame_start;
  logic [9:0]    x, y;
  logic [CW-1:0] color;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .COLOR_W(CW), .NUM_BARS(NB), .CHECK_LOG2(CL), .SYNC_POL(POL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_color(solid),
    .hsync(hsync), .vsync(vsync), .active(active), .x(x), .y(y),
    .color(color), .frame_start(frame_start), .frame_count(frame_count)
  );

  int passed = 0, total = 0;
  int ph = 0, pv = 0, lmode = 0, lsolid = 0, e_x = 0, e_y = 0, e_col = 0, e_fc = 0;
  bit seen = 0, valid = 0, e_hs = 1, e_vs = 1, e_act = 0, e_fs = 0;
  int cyc = 0, last_fs = 0, period = 0;
  logic [CW-1:0] obs_col [HT][VT];
  bit obs_hs [HT][VT];
  bit obs_vs [HT][VT];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int pattern(input int m, input int s, input int h, input int v);
    case (m)
      0: return (h / (HA / NB)) % (1 << CW);
      1: return (((h >> CL) ^ (v >> CL)) & 1) ? CMAX : 0;
      2: return (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) ? CMAX : 0;
      default: return s;
    endcase
  endfunction

  task automatic step();
    logic [42:0] expv, actv;
    bit org;
    @(posedge clk);
    cyc++;
    if (rst) begin
      ph = 0; pv = 0; lmode = 0; lsolid = 0; seen = 0; valid = 1;
      e_hs = !POL; e_vs = !POL; e_act = 0; e_x = 0; e_y = 0; e_col = 0; e_fs = 0; e_fc = 0;
    end else if (en) begin
      org = (ph == 0 && pv == 0);
      if (org) begin lmode = int'(mode); lsolid = int'(solid); end
      e_hs  = (ph >= HA + HFP && ph < HA + HFP + HS) ? POL : !POL;
      e_vs  = (pv >= VA + VFP && pv < VA + VFP + VS) ? POL : !POL;
      e_act = (ph < HA) && (pv < VA);
      e_x = ph; e_y = pv;
      e_col = e_act ? pattern(lmode, lsolid, ph, pv) : 0;
      e_fs = org;
      if (org) begin
        if (seen) e_fc = (e_fc + 1) % 65536;
        seen = 1;
      end
      ph++;
      if (ph == HT) begin ph = 0; pv = (pv + 1) % VT; end
    end
    #1;
    if (valid) begin
      expv = {e_hs, e_vs, e_act, 10'(e_x), 10'(e_y), 3'(e_col), e_fs, 16'(e_fc)};
      actv = {hsync, vsync, active, x, y, color, frame_start, frame_count};
      total++;
      if (actv === expv) passed++;
      else $display("FAIL cycle %0d outputs: got %h expected %h (pos %0d,%0d)", cyc, actv, expv, e_x, e_y);
      if (x < 10'(HT) && y < 10'(VT)) begin
        obs_col[x][y] = color;
        obs_hs[x][y]  = hsync;
        obs_vs[x][y]  = vsync;
      end
      if (en && !rst && frame_start) begin period = cyc - last_fs; last_fs = cyc; end
    end
  endtask

  task automatic wait_pos(input int tx, input int ty);
    for (int i = 0; i < 1000 && !(ph == tx && pv == ty); i++) step();
    check("wait_pos_reached", int'(ph == tx && pv == ty), 1);
  endtask

  initial begin
    int cnt, first;
    int fc0;
    // reset with en low still applies
    rst = 1; en = 0;
    step(); step();
    check("reset_hsync", int'(hsync), 1);
    check("reset_fs", int'(frame_start), 0);
    check("reset_fc", int'(frame_count), 0);
    rst = 0; en = 1; mode = 2'd0;
    step();
    check("first_fs", int'(frame_start), 1);
    check("first_xy", int'({x, y}), 0);
    last_fs = cyc;
    for (int i = 0; i < 2 * HT * VT + 2; i++) step();
    check("frame_period", period, HT * VT);
    check("bar_x4", int'(obs_col[4][0]), 1);
    check("bar_x15", int'(obs_col[15][0]), 3);
    check("blank_x16", int'(obs_col[16][0]), 0);
    cnt = 0; first = -1;
    for (int i = 0; i < HT; i++) if (!obs_hs[i][0]) begin cnt++; if (first < 0) first = i; end
    check("hsync_width", cnt, 3);
    check("hsync_start", first, 18);
    check("vsync_l13", int'(obs_vs[0][13]), 1);
    check("vsync_l14", int'(obs_vs[0][14]), 0);
    check("vsync_l15_xend", int'(obs_vs[HT-1][15]), 0);
    check("vsync_l16", int'(obs_vs[0][16]), 1);

    mode = 2'd1;
    for (int i = 0; i < 2 * HT * VT; i++) step();
    check("checker_4_0", int'(obs_col[4][0]), 7);
    check("checker_4_4", int'(obs_col[4][4]), 0);
    check("checker_0_4", int'(obs_col[0][4]), 7);

    // switch to solid mid-frame; bars must persist until the frame boundary
    mode = 2'd0;
    wait_pos(0, 0);
    step();
    wait_pos(10, 6);
    mode = 2'd3; solid = 3'd5;
    fc0 = int'(frame_count);
    for (int i = 0; i < HT * VT + 10 && !frame_start; i++) step();
    check("switch_fs_seen", int'(frame_start), 1);
    check("switch_color", int'(color), 5);
    check("switch_fc", int'(frame_count), (fc0 + 1) % 65536);
    check("bars_kept_12_8", int'(obs_col[12][8]), 3);

    for (int i = 0; i < 2500; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) solid = CW'($urandom_range(0, CMAX));
      step();
    end

    en = 1;
    wait_pos(10, 7);
    rst = 1;
    step();
    check("rst_mid_xy", int'({x, y}), 0);
    check("rst_mid_color", int'(color), 0);
    check("rst_mid_active", int'(active), 0);
    check("rst_mid_vsync", int'(vsync), 1);
    rst = 0;
    step();
    check("post_rst_fs", int'(frame_start), 1);
    check("post_rst_fc", int'(frame_count), 0);
    step();
    for (int i = 0; i < HT * VT + 10 && !frame_start; i++) step();
    check("second_fs_seen", int'(frame_start), 1);
    check("second_fs_fc", int'(frame_count), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Parametrised VGA timing and test-pattern generator. Next generation of the free-running colour-bar block.
- Adds hsync/vsync and an active-video flag, configurable porch and sync timing, and a colour width parameter.
- Offers four selectable patterns and a frame counter.
- Sits between the pixel-clock domain and the DAC/pin driver. Used for bring-up of the display path before game rendering.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- COLOR_W, 3, bits of colour per pixel
- NUM_BARS, 8, colour bars across H_ACTIVE; H_ACTIVE must be divisible by NUM_BARS
- CHECK_LOG2, 5, checker square edge = 2^CHECK_LOG2 pixels
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- en  in  1  pixel enable; when low all state and outputs hold
- mode  in  2  pattern select: 0 bars, 1 checker, 2 border, 3 solid
- solid_color  in  COLOR_W  colour used in mode 3
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- active  out  1  high during visible pixels
- x  out  10  pixel column of the current output pixel
- y  out  10  line of the current output pixel
- color  out  COLOR_W  pixel colour
- frame_start  out  1  one-cycle pulse on the output of pixel (0,0)
- frame_count  out  16  completed-frame counter, wraps at 2^16

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Counters are 10 bits; elaboration fails if either total exceeds 1024.
- Counters (internal):
  - h_cnt increments on each en cycle and wraps H_TOTAL-1 -> 0.
  - v_cnt increments when h_cnt wraps, and wraps V_TOTAL-1 -> 0.
- Output stage: one registered stage. Every output for counter position (h,v) appears together, one en-cycle later. All outputs are mutually aligned.
- Sync windows:
  - hsync is at SYNC_POL when h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751), otherwise !SYNC_POL.
  - vsync uses the same rule on v (490..491) and is independent of h.
- Visible region: active = (h < H_ACTIVE) && (v < V_ACTIVE). x/y carry h/v. When active is low, color = 0.
- Pattern latching: mode and solid_color are sampled only when the counter is at (0,0). Changes take effect at the next frame and never mid-frame.
- Patterns (visible pixels only):
  - Bars: color = bar index mod 2^COLOR_W, where index = h / (H_ACTIVE/NUM_BARS). Implement with a bar-width sub-counter, no divider. Defaults give 0..7 in 80-pixel bars.
  - Checker: all-ones if h[CHECK_LOG2] ^ v[CHECK_LOG2], else 0.
  - Border: all-ones when h==0, h==H_ACTIVE-1, v==0 or v==V_ACTIVE-1, else 0.
  - Solid: latched solid_color.
- frame_start: high for the single output cycle carrying (0,0).
- frame_count: increments in the same cycle frame_start is output, except for the first frame after reset.
- Reset values, applied on the cycle after rst is sampled high, regardless of en or mid-frame position:
  - Counters 0; latched mode 0; latched colour 0.
  - hsync = vsync = !SYNC_POL; active 0; x = y = 0; color 0; frame_start 0; frame_count 0.
- After rst deasserts with en high: the first output (pixel 0,0 with frame_start = 1) appears one cycle later.
- en low during reset: reset still applies. Counting resumes only once en is high.

Decomposition:
- Shared package vga_pkg holds:
  - Mode enum: MODE_BARS, MODE_CHECKER, MODE_BORDER, MODE_SOLID.
  - Default timing constants and the total-computation functions.
- Natural sub-module: vga_timing. It contains the h/v counters, sync-window decode and active flag.
- vga_pattern_gen instantiates vga_timing and adds the pattern logic, the mode latch and the output register stage.

Test Plan:
- Defaults, en=1, run 2 frames -> hsync low for exactly 96 cycles per line, starting 656 cycles after line start. vsync low for 2 lines (490-491). Frame period 420000 cycles.
- mode=0, line 0 -> color 0 for x 0..79, 1 for 80..159, …, 7 for 560..639. color 0 during x 640..799.
- mode=1 -> color 7 at (32,0), 0 at (32,32), 7 at (0,32).
- mode switched 0->3 with solid_color=5 at mid-frame (x=300,y=200) -> bars continue to the end of the frame; first pixel of the next frame is 5. frame_count increments by 1 at that boundary.
- en toggled 1-0-1 in a random pattern -> output sequence identical to the en=1 run with the stall cycles removed; outputs hold while en=0.
- rst pulsed at (x=500,y=300) -> next cycle all outputs equal reset values. frame_start=1 with x=y=0 one cycle after rst drops; frame_count stays 0 until the second frame start.
